dmem_responder: RTL

//   Responder (memory side) for the pipeline's data load/store port. Replaces the inline data array with a

---
 rtl/dmem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Handshaked, multi-cycle, big-endian byte-addressed data memory responder (one request in flight).
// Optional build macro: DMEM_MISALIGN_ERR_EN adds rsp_err and turns misaligned accesses into error responses.
module dmem_responder #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        start,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        busy
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic        rsp_err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic                we_p0;
    logic [ADDR_W-1:0]   addr_p0;
    logic [31:0]         wdata_p0;
    logic [7:0]          mem [DEPTH];
    logic                accept;
    logic                access;
    logic                misalign;
    logic [ADDR_W-1:0]   a1, a2, a3;
    logic                unused_addr_hi;

    assign accept = (state == IDLE) && req_valid && !start;
    assign access = (state == WAIT) && (cnt == 4'd0);

    // Byte offsets wrap naturally modulo DEPTH through the ADDR_W-bit adders.
    assign a1 = addr_p0 + ADDR_W'(1);
    assign a2 = addr_p0 + ADDR_W'(2);
    assign a3 = addr_p0 + ADDR_W'(3);

    assign unused_addr_hi = ^req_addr[31:ADDR_W];

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign = (addr_p0[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge start) begin
        if (start) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !start;
                if (accept) state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: request fields captured on the accepting edge only.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            addr_p0  <= req_addr[ADDR_W-1:0];
            wdata_p0 <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= 4'(LATENCY - 1);
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response data is only updated on the access edge, so it stays stable through RESP.
    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            rsp_rdata <= 32'd0;
        end else if (access) begin
            if (we_p0 || misalign) rsp_rdata <= 32'd0;
            else                   rsp_rdata <= {mem[addr_p0], mem[a1], mem[a2], mem[a3]};
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    always_ff @(posedge clk or posedge start) begin
        if (start)       rsp_err <= 1'b0;
        else if (access) rsp_err <= misalign;
    end
`endif

    // Storage is never cleared; a write is suppressed if reset is asserted on the access edge.
    always_ff @(posedge clk) begin
        if (access && we_p0 && !misalign && !start) begin
            mem[addr_p0] <= wdata_p0[31:24];
            mem[a1]      <= wdata_p0[23:16];
            mem[a2]      <= wdata_p0[15:8];
            mem[a3]      <= wdata_p0[7:0];
        end
    end

endmodule
